pipelined_add_sub: RTL and testbench

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

---
 rtl/pipelined_add_sub.sv | 134 +++++++++++++
 tb/tb_pipelined_add_sub.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor. Each stage adds one WIDTH/STAGES slice with
// 4-bit carry-lookahead groups chained by ripple, under a global stall enable.
module pipelined_add_sub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);

  localparam int unsigned SLICE  = WIDTH / STAGES;
  localparam int unsigned GROUPS = SLICE / 4;
  localparam int unsigned LAST   = STAGES - 1;

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];

  logic             en;
  logic [WIDTH-1:0] beff;
  logic             ceff;
  logic [SLICE:0]   slice_res;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Returns {carry_out, slice_sum}.
  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic ci);
    logic [SLICE-1:0] s;
    logic             c;
    logic [4:0]       grp;
    s = '0;
    c = ci;
    for (int unsigned i = 0; i < GROUPS; i++) begin
      grp          = cla4(a[i*4 +: 4], b[i*4 +: 4], c);
      s[i*4 +: 4]  = grp[3:0];
      c            = grp[4];
    end
    return {c, s};
  endfunction

  assign en       = !valid_q[LAST] || out_ready;
  assign in_ready = en;
  assign beff     = Sub ? ~In2 : In2;
  assign ceff     = Sub | Cin;

  always_comb begin
    valid_d   = valid_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    a_d       = a_q;
    b_d       = b_q;
    slice_res = '0;
    if (en) begin
      // Stage 0 captures Beff, so the add/sub choice rides with its request.
      slice_res               = slice_add(In1[SLICE-1:0], beff[SLICE-1:0], ceff);
      valid_d[0]              = in_valid;
      a_d[0]                  = In1;
      b_d[0]                  = beff;
      sum_d[0]                = '0;
      sum_d[0][SLICE-1:0]     = slice_res[SLICE-1:0];
      carry_d[0]              = slice_res[SLICE];
      for (int unsigned k = 1; k < STAGES; k++) begin
        slice_res                  = slice_add(a_q[k-1][k*SLICE +: SLICE],
                                               b_q[k-1][k*SLICE +: SLICE],
                                               carry_q[k-1]);
        valid_d[k]                 = valid_q[k-1];
        a_d[k]                     = a_q[k-1];
        b_d[k]                     = b_q[k-1];
        sum_d[k]                   = sum_q[k-1];
        sum_d[k][k*SLICE +: SLICE] = slice_res[SLICE-1:0];
        carry_d[k]                 = slice_res[SLICE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '{default: 1'b0};
      carry_q <= '{default: 1'b0};
      sum_q   <= '{default: '0};
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign Sum       = sum_q[LAST];
  assign Carry     = carry_q[LAST];
  assign Zero      = (sum_q[LAST] == '0);
  assign Overflow  = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                     (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub (WIDTH=32, STAGES=2): latency, flags,
// stall/back-pressure ordering and reset flush.
module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        Cin;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Sum;
  logic        Carry;
  logic        Overflow;
  logic        Zero;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .In1(In1), .In2(In2), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Carry(Carry), .Overflow(Overflow), .Zero(Zero)
  );

  // Back-to-back request table with hand-computed results.
  logic [31:0] qa   [4] = '{32'd1, 32'h0000FFFF, 32'd10, 32'hFFFFFFFF};
  logic [31:0] qb   [4] = '{32'd2, 32'h00000001, 32'd3,  32'hFFFFFFFF};
  logic        qc   [4] = '{1'b0,  1'b0,         1'b0,   1'b1};
  logic        qsub [4] = '{1'b0,  1'b0,         1'b1,   1'b0};
  logic [31:0] qs   [4] = '{32'd3, 32'h00010000, 32'd7,  32'hFFFFFFFF};
  logic        qcar [4] = '{1'b0,  1'b0,         1'b1,   1'b1};

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    in_valid = v;
    In1      = a;
    In2      = b;
    Cin      = c;
    Sub      = s;
  endtask

  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic [31:0] exp_sum,
                        input logic exp_c, input logic exp_v, input logic exp_z);
    drive(1'b1, a, b, c, s);
    #1;
    chk1({tag, ".in_ready"}, in_ready, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk1({tag, ".lat1_valid"}, out_valid, 1'b0);
    tick();
    chk1 ({tag, ".valid"},    out_valid, 1'b1);
    chk32({tag, ".sum"},      Sum,       exp_sum);
    chk1 ({tag, ".carry"},    Carry,     exp_c);
    chk1 ({tag, ".overflow"}, Overflow,  exp_v);
    chk1 ({tag, ".zero"},     Zero,      exp_z);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int tx;
    int rx;
    int stall;
    bit seen;

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk1 ("reset.out_valid", out_valid, 1'b0);
    chk1 ("reset.in_ready",  in_ready,  1'b1);
    chk32("reset.sum",       Sum,       32'h0);
    chk1 ("reset.carry",     Carry,     1'b0);
    chk1 ("reset.overflow",  Overflow,  1'b0);
    chk1 ("reset.zero",      Zero,      1'b1);

    single("allones", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    single("sovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    single("sub5m7",  32'd5,        32'd7,        1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    single("sub7m5",  32'd7,        32'd5,        1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0);
    single("xstage",  32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0, 1'b0);
    single("subovf",  32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

    // Drain the last single-shot result before the streaming test.
    tick();
    chk1("drain.valid", out_valid, 1'b0);

    tx    = 0;
    rx    = 0;
    stall = 0;
    seen  = 1'b0;
    for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
      if (out_valid && !seen) begin
        seen  = 1'b1;
        stall = 3;
      end
      out_ready = (stall == 0);
      if (tx < 4) drive(1'b1, qa[tx], qb[tx], qc[tx], qsub[tx]);
      else        drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      if (stall > 0) chk1("b2b.stall_in_ready", in_ready, 1'b0);
      if (out_valid) begin
        chk32("b2b.sum",   Sum,   qs[rx]);
        chk1 ("b2b.carry", Carry, qcar[rx]);
        if (out_ready) rx++;
      end
      if (in_valid && in_ready) tx++;
      tick();
      if (stall > 0) stall--;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    chk32("b2b.rx_count", 32'(rx), 32'd4);
    chk32("b2b.tx_count", 32'(tx), 32'd4);
    #1;
    chk1("b2b.drained", out_valid, 1'b0);

    drive(1'b1, 32'd100, 32'd200, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd300, 32'd400, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'd500, 32'd600, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk1 ("rstmid.out_valid", out_valid, 1'b0);
    chk1 ("rstmid.in_ready",  in_ready,  1'b1);
    chk32("rstmid.sum",       Sum,       32'h0);
    chk1 ("rstmid.zero",      Zero,      1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("rstmid.flushed", out_valid, 1'b0);
    end
    single("postrst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
